// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: address width, maximum
// instruction-block length, default I/O window base and the load/store
// size encodings, plus a helper that turns a size code into a byte count.
package mem_ctrl_pkg;

    localparam int unsigned         ADDR_WID         = 32;
    localparam int unsigned         CACHE_BLK_MAXLEN = 64;
    localparam logic [ADDR_WID-1:0] IO_BASE_ADDR     = 32'h0003_0000;

    localparam logic [1:0] LSB_LEN_BYTE = 2'b00;
    localparam logic [1:0] LSB_LEN_HALF = 2'b01;
    localparam logic [1:0] LSB_LEN_WORD = 2'b11;

    // Byte count of a load/store; the unused code 2'b10 is treated as a word.
    function automatic logic [2:0] lsb_len_bytes(input logic [1:0] len);
        case (len)
            LSB_LEN_BYTE: return 3'd1;
            LSB_LEN_HALF: return 3'd2;
            LSB_LEN_WORD: return 3'd4;
            default:      return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter serving instruction-block fills and load/store
// accesses. The load/store port wins over the fetch port. Reads have a
// one-cycle RAM latency, so byte k is captured two edges after its address
// was launched. Stores to the I/O window stall while the UART is full.
//
// Ports:
//   clk, rst (async, active low), rdy (global enable), rollback (flush)
//   io_buffer_full                       UART back-pressure
//   mem_din / mem_dout / mem_a / mem_wr  byte RAM interface
//   if_find_valid/_addr, if_data_valid/if_data   block fill request/response
//   lsb_valid/_wr/_len/_addr/_wdata, lsb_done/lsb_rdata  load/store port
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned         CACHE_BLK_BYTES = CACHE_BLK_MAXLEN,
    parameter logic [ADDR_WID-1:0] IO_BASE         = IO_BASE_ADDR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         rollback,
    input  logic                         io_buffer_full,
    input  logic [7:0]                   mem_din,
    output logic [7:0]                   mem_dout,
    output logic [ADDR_WID-1:0]          mem_a,
    output logic                         mem_wr,
    input  logic                         if_find_valid,
    input  logic [ADDR_WID-1:0]          if_find_addr,
    output logic                         if_data_valid,
    output logic [8*CACHE_BLK_BYTES-1:0] if_data,
    input  logic                         lsb_valid,
    input  logic                         lsb_wr,
    input  logic [1:0]                   lsb_len,
    input  logic [ADDR_WID-1:0]          lsb_addr,
    input  logic [31:0]                  lsb_wdata,
    output logic                         lsb_done,
    output logic [31:0]                  lsb_rdata
);

    localparam int unsigned BLK_W = 8 * CACHE_BLK_BYTES;
    localparam int unsigned CNT_W = ($clog2(CACHE_BLK_BYTES + 2) > 7) ?
                                    $clog2(CACHE_BLK_BYTES + 2) : 7;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_IF_READ  = 2'd1;
    localparam logic [1:0] ST_LS_READ  = 2'd2;
    localparam logic [1:0] ST_LS_WRITE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [BLK_W-1:0]    asm_q, asm_d;
    logic [ADDR_WID-1:0] mem_a_q, mem_a_d;
    logic                mem_wr_q, mem_wr_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic [BLK_W-1:0]    if_data_q, if_data_d;
    logic                if_valid_q, if_valid_d;
    logic [31:0]         lsb_rdata_q, lsb_rdata_d;
    logic                lsb_done_q, lsb_done_d;

    logic                lsb_take, if_take, rd_last, wr_last, io_stall;
    logic [ADDR_WID-1:0] byte_addr;
    logic [CNT_W-1:0]    rd_idx;

    // A port whose completion pulse is still high is not re-accepted.
    assign lsb_take  = lsb_valid && !lsb_done_q;
    assign if_take   = if_find_valid && !if_valid_q && !rollback;
    assign byte_addr = addr_q + ADDR_WID'(cnt_q);
    assign rd_last   = (cnt_q == len_q + CNT_W'(1));
    assign wr_last   = (cnt_q >= len_q);
    assign rd_idx    = cnt_q - CNT_W'(2);
    assign io_stall  = io_buffer_full && (byte_addr >= IO_BASE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lsb_take) begin
                    state_d = lsb_wr ? ST_LS_WRITE : ST_LS_READ;
                end else if (if_take) begin
                    state_d = ST_IF_READ;
                end
            end
            ST_IF_READ:  if (rollback || rd_last) state_d = ST_IDLE;
            ST_LS_READ:  if (rd_last) state_d = ST_IDLE;
            ST_LS_WRITE: if (wr_last) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        mem_a_d     = mem_a_q;
        mem_wr_d    = 1'b0;
        mem_dout_d  = mem_dout_q;
        if_data_d   = if_data_q;
        if_valid_d  = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
        lsb_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_a_d = '0;
                cnt_d   = '0;
                if (lsb_take) begin
                    addr_d  = lsb_addr;
                    wdata_d = lsb_wdata;
                    len_d   = CNT_W'(lsb_len_bytes(lsb_len));
                    // Reads launch byte 0 at the accepting edge; writes start next edge.
                    if (!lsb_wr) begin
                        mem_a_d = lsb_addr;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (if_take) begin
                    addr_d  = if_find_addr;
                    len_d   = CNT_W'(CACHE_BLK_BYTES);
                    mem_a_d = if_find_addr;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_IF_READ, ST_LS_READ: begin
                if (state_q == ST_IF_READ && rollback) begin
                    mem_a_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < len_q) begin
                        mem_a_d = byte_addr;
                    end
                    // cnt counts edges since acceptance; data trails address by two.
                    if (cnt_q >= CNT_W'(2)) begin
                        for (int unsigned k = 0; k < CACHE_BLK_BYTES; k++) begin
                            if (rd_idx == CNT_W'(k)) begin
                                asm_d[8*k +: 8] = mem_din;
                            end
                        end
                    end
                    if (rd_last) begin
                        mem_a_d = '0;
                        cnt_d   = '0;
                        if (state_q == ST_IF_READ) begin
                            if_data_d  = asm_d;
                            if_valid_d = 1'b1;
                        end else begin
                            lsb_rdata_d = '0;
                            for (int unsigned k = 0; k < 4; k++) begin
                                if (CNT_W'(k) < len_q) begin
                                    lsb_rdata_d[8*k +: 8] = asm_d[8*k +: 8];
                                end
                            end
                            lsb_done_d = 1'b1;
                        end
                    end
                end
            end
            ST_LS_WRITE: begin
                if (!wr_last) begin
                    if (!io_stall) begin
                        mem_wr_d   = 1'b1;
                        mem_a_d    = byte_addr;
                        mem_dout_d = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
                        cnt_d      = cnt_q + CNT_W'(1);
                    end
                end else begin
                    mem_a_d    = '0;
                    cnt_d      = '0;
                    lsb_done_d = 1'b1;
                end
            end
            default: begin
                mem_a_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= '0;
            if_data_q   <= '0;
            if_valid_q  <= 1'b0;
            lsb_rdata_q <= '0;
            lsb_done_q  <= 1'b0;
        end else if (rdy) begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            mem_a_q     <= mem_a_d;
            mem_wr_q    <= mem_wr_d;
            mem_dout_q  <= mem_dout_d;
            if_data_q   <= if_data_d;
            if_valid_q  <= if_valid_d;
            lsb_rdata_q <= lsb_rdata_d;
            lsb_done_q  <= lsb_done_d;
        end
    end

    // The write strobe is gated so a frozen controller never writes.
    assign mem_wr        = mem_wr_q & rdy;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign if_data       = if_data_q;
    assign if_data_valid = if_valid_q;
    assign lsb_rdata     = lsb_rdata_q;
    assign lsb_done      = lsb_done_q;

endmodule
